baud_gen_frac: RTL and testbench

- Programmable fractional baud-rate tick generator, parametrised in clock frequency, oversampling ratio and divisor precision.
- Produces an oversample tick (`tick`) and a bit-rate tick (`bit_tick`).
- Divisor is reloadable at run time through a valid/ready handshake, with changes applied glitch-free at a period boundary.
- A phase-resync input lets the UART receiver align `bit_tick` to mid-bit on start-bit detection. Sits between the clock domain root and UART TX/RX.

---
 rtl/baud_pkg.sv | 25 ++
 rtl/baud_frac_div.sv | 59 +++++
 rtl/baud_gen_frac.sv | 97 +++++++++
 tb/tb_baud_gen_frac.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared widths, baud constants and the divisor helper
// for the fractional baud-rate generator.
package baud_pkg;

    localparam int DIV_W = 16 + 8;

    localparam int BAUD_9600   = 9600;
    localparam int BAUD_115200 = 115200;
    localparam int BAUD_921600 = 921600;

    // Rounded {I,F}: clk_hz * 2^frac / (os * baud).
    function automatic logic [63:0] calc_div(
        input longint clk_hz,
        input longint baud,
        input longint os,
        input int     frac
    );
        longint den;
        longint num;
        den = os * baud;
        num = (clk_hz << frac) + den / 2;
        return 64'(num / den);
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional period core: cnt/acc/extend, registered tick.
// Ports: clk, rst, en, clear, load, div_i/div_f in; last, tick out.
module baud_frac_div #(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 load,
    input  logic [INT_BITS-1:0]  div_i,
    input  logic [FRAC_BITS-1:0] div_f,
    output logic                 last,
    output logic                 tick
);

    logic [INT_BITS-1:0]  cnt;
    logic [INT_BITS-1:0]  len_m1;
    logic [FRAC_BITS-1:0] acc;
    logic                 ext;
    logic [FRAC_BITS:0]   sum;

    assign len_m1 = div_i
                  + {{(INT_BITS-1){1'b0}}, ext}
                  - {{(INT_BITS-1){1'b0}}, 1'b1};

    // >= rather than == so a divisor shrunk while frozen
    // cannot strand cnt beyond the new period end.
    assign last = (cnt >= len_m1);
    assign sum  = {1'b0, acc} + {1'b0, div_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            acc  <= '0;
            ext  <= 1'b0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            acc  <= '0;
            ext  <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= en & last;
            if (en) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (load) begin
                acc <= '0;
                ext <= 1'b0;
            end else if (en && last) begin
                acc <= sum[FRAC_BITS-1:0];
                ext <= sum[FRAC_BITS];
            end
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick, bit tick, divisor reload.
// Ports: clk, rst, en, sync, div_in/div_valid/div_ready, cur_div, tick, bit_tick, cfg_err.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int DEFAULT_BAUD = BAUD_115200,
    parameter int OVERSAMPLE   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int INT_BITS     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync,
    input  logic [INT_BITS+FRAC_BITS-1:0] div_in,
    input  logic                          div_valid,
    output logic                          div_ready,
    output logic [INT_BITS+FRAC_BITS-1:0] cur_div,
    output logic                          tick,
    output logic                          bit_tick,
    output logic                          cfg_err
);

    localparam int DW  = INT_BITS + FRAC_BITS;
    localparam int OSW = $clog2(OVERSAMPLE);

    localparam logic [63:0] DEF_FULL = calc_div(
        longint'(CLK_FREQ_HZ), longint'(DEFAULT_BAUD),
        longint'(OVERSAMPLE), FRAC_BITS);

    localparam logic [DW-1:0]  DIV_DEFAULT = DEF_FULL[DW-1:0];
    localparam logic [DW-1:0]  DIV_CLAMP   = {INT_BITS'(2), FRAC_BITS'(0)};
    localparam logic [OSW-1:0] OS_LAST     = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF     = OSW'(OVERSAMPLE / 2);

    logic [DW-1:0]  pend;
    logic           pend_vld;
    logic [OSW-1:0] os_cnt;
    logic           last;
    logic           fire;
    logic           apply;
    logic           accept;
    logic           clamp;

    assign div_ready = ~pend_vld;
    assign accept    = div_valid & div_ready;
    assign clamp     = div_in[DW-1:FRAC_BITS] < INT_BITS'(2);
    assign fire      = en & last & ~sync;

    // Frozen counters have no boundary to wait for, so apply at once.
    assign apply = pend_vld & (sync | ~en | last);

    baud_frac_div #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (sync),
        .load  (apply),
        .div_i (cur_div[DW-1:FRAC_BITS]),
        .div_f (cur_div[FRAC_BITS-1:0]),
        .last  (last),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt   <= '0;
            bit_tick <= 1'b0;
            cur_div  <= DIV_DEFAULT;
            pend     <= '0;
            pend_vld <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            bit_tick <= fire & (os_cnt == OS_LAST);
            if (sync) begin
                os_cnt <= OS_HALF;
            end else if (fire) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end
            if (apply) begin
                cur_div  <= pend;
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend     <= clamp ? DIV_CLAMP : div_in;
                pend_vld <= 1'b1;
                if (clamp) begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick spacing, bit ticks,
// divisor handshake, sync, freeze, clamp and reset.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync;
    logic [23:0] div_in;
    logic        div_valid;
    logic        div_ready;
    logic [23:0] cur_div;
    logic        tick;
    logic        bit_tick;
    logic        cfg_err;

    typedef struct {
        int   gap;
        logic bt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_t = 0;
    int   os_model = 0;
    int   def_i;
    int   def_f;
    logic [23:0] def_div;

    baud_gen_frac dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .cur_div   (cur_div),
        .tick      (tick),
        .bit_tick  (bit_tick),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_tick(output int gap, output logic bt);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 2000);
        if (tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_timeout got=none want=tick in 2000 cycles");
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "no tick");
        end
        gap = cyc - last_t;
        last_t = cyc;
        bt = bit_tick;
    endtask

    // Absolute time of the n-th tick since the accumulator was cleared.
    function automatic int t_of(int i, int f, int n);
        if (n <= 0) return 0;
        return n * i + ((n - 1) * f) / 256;
    endfunction

    task automatic push_run(int i, int f, int n0, int cnt);
        for (int k = 0; k < cnt; k++) begin
            exp_t e;
            e.gap = t_of(i, f, n0 + k) - t_of(i, f, n0 + k - 1);
            e.bt  = (os_model == 15);
            sb.push_back(e);
            os_model = (os_model + 1) % 16;
        end
    endtask

    task automatic drain(input string tag);
        int   g;
        logic b;
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(g, b);
            chk({tag, "_gap"}, 64'(g), 64'(e.gap));
            chk({tag, "_bit_tick"}, 64'(b), 64'(e.bt));
        end
    endtask

    initial begin
        int   g;
        logic b;
        int   sum;
        int   bt_cnt;
        int   bt_exp;
        longint den;

        den = 64'd16 * 64'd115200;
        def_div = 24'((longint'(100_000_000) * 256 + den / 2) / den);
        def_i = int'(def_div[23:8]);
        def_f = int'(def_div[7:0]);

        rst = 1'b1;
        en = 1'b1;
        sync = 1'b0;
        div_in = '0;
        div_valid = 1'b0;
        repeat (3) step();
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_bit_tick", 64'(bit_tick), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_div_ready", 64'(div_ready), 64'd1);
        chk("rst_cur_div", 64'(cur_div), 64'(def_div));
        rst = 1'b0;
        last_t = cyc;

        // Default divisor: 20 ticks, bit_tick on the 16th.
        push_run(def_i, def_f, 1, 20);
        drain("dflt");

        // Reload mid-period; the running period keeps its length.
        repeat (10) step();
        div_in = 24'h000A00;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        chk("hs_ready_low", 64'(div_ready), 64'd0);
        chk("hs_cur_old", 64'(cur_div), 64'(def_div));
        push_run(def_i, def_f, 21, 1);
        drain("hs_old");
        chk("hs_cur_new", 64'(cur_div), 64'h000A00);
        chk("hs_ready_high", 64'(div_ready), 64'd1);
        push_run(10, 0, 1, 4);
        drain("hs_new");

        // Sync exactly on a would-be tick.
        repeat (9) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_suppress", 64'(tick), 64'd0);
        last_t = cyc;
        os_model = 8;
        push_run(10, 0, 1, 8);
        drain("sync");

        // Freeze for 20 cycles inside a period.
        sb.push_back('{30, os_model == 15});
        os_model = (os_model + 1) % 16;
        push_run(10, 0, 1, 1);
        repeat (4) step();
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("freeze_tick", 64'(tick), 64'd0);
        end
        en = 1'b1;
        drain("freeze");

        // Fractional divisor 6.5.
        repeat (3) step();
        div_in = 24'h000680;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        chk("frac_ready_low", 64'(div_ready), 64'd0);
        push_run(10, 0, 1, 1);
        push_run(6, 128, 1, 5);
        drain("frac");
        sum = 0;
        bt_cnt = 0;
        bt_exp = 0;
        for (int k = 0; k < 1000; k++) begin
            wait_tick(g, b);
            sum += g;
            bt_cnt += int'(b);
            if (os_model == 15) bt_exp++;
            os_model = (os_model + 1) % 16;
        end
        chk("frac_sum_1000", 64'(sum), 64'd6500);
        chk("frac_bit_ticks", 64'(bt_cnt), 64'(bt_exp));

        // Divisor below 2 is clamped and flagged.
        repeat (2) step();
        div_in = 24'h000100;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        chk("clamp_cfg_err", 64'(cfg_err), 64'd1);
        push_run(6, 128, 1006, 1);
        push_run(2, 0, 1, 3);
        drain("clamp");
        chk("clamp_cur_div", 64'(cur_div), 64'h000200);
        chk("clamp_err_sticky", 64'(cfg_err), 64'd1);

        // Reset with a divisor pending.
        step();
        div_in = 24'h000500;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        chk("pend_ready_low", 64'(div_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst2_cur_div", 64'(cur_div), 64'(def_div));
        chk("rst2_div_ready", 64'(div_ready), 64'd1);
        chk("rst2_tick", 64'(tick), 64'd0);
        last_t = cyc;
        os_model = 0;
        push_run(def_i, def_f, 1, 2);
        drain("rst2");
        chk("rst2_pend_gone", 64'(cur_div), 64'(def_div));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
